// File: rtl/cnn_window_feeder.sv
// cnn_window_feeder: holds one IMG_W x IMG_W image and streams every WIN x WIN
// window in raster order (X = row origin, Y = column origin), then waits
// for the CNN to report a class and returns it upstream.
// Optional macro CNN_WINDOW_FEEDER_READY_EN adds a READY back-pressure input.
module cnn_window_feeder #(
    parameter int IMG_W = 28,
    parameter int WIN   = 5,
    parameter int PIX_W = 8
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     WE,
    input  logic [9:0]               WADDR,
    input  logic [PIX_W-1:0]         WDATA,
    input  logic                     START,
    output logic                     BUSY,
    output logic [4:0]               X,
    output logic [4:0]               Y,
    output logic [WIN*WIN*PIX_W-1:0] IMGIN,
    output logic                     VALID,
`ifdef CNN_WINDOW_FEEDER_READY_EN
    input  logic                     READY,
`endif
    input  logic                     CNN_DONE,
    input  logic [3:0]               CNN_OUT,
    output logic [3:0]               RESULT,
    output logic                     RESULT_VALID
);

    localparam int POS   = IMG_W - WIN + 1;
    localparam int NPIX  = IMG_W * IMG_W;
    localparam int AW    = 10;
    localparam int TAPS  = WIN * WIN;
    localparam logic [4:0]    LAST_POS = 5'(POS - 1);
    localparam logic [AW-1:0] NPIX_A   = AW'(NPIX);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT_DONE} state_t;

    state_t state_q, state_d;

    logic [PIX_W-1:0] mem [NPIX];

    logic                     accept;
    logic                     last_win;
    logic                     start_acc;
    logic                     load_win;
    logic                     end_scan;
    logic                     capture;
    logic                     wr_en;
    logic [4:0]               nx, ny;
    logic [TAPS*PIX_W-1:0]    imgin_d;

`ifdef CNN_WINDOW_FEEDER_READY_EN
    assign accept = READY;
`else
    assign accept = 1'b1;
`endif

    assign last_win = (X == LAST_POS) && (Y == LAST_POS);
    assign wr_en    = WE && (state_q == IDLE) && (WADDR < NPIX_A);

    // Next window origin: restart at 0,0 when nothing is on the bus yet,
    // otherwise step Y and wrap into the next row.
    always_comb begin
        nx = X;
        ny = Y;
        if (!VALID) begin
            nx = '0;
            ny = '0;
        end else if (Y == LAST_POS) begin
            nx = X + 5'd1;
            ny = '0;
        end else begin
            ny = Y + 5'd1;
        end
    end

    // One read tap per window pixel; byte (i*WIN+j) = img[(nx+i)*IMG_W + ny+j].
    for (genvar i = 0; i < WIN; i++) begin : g_row
        for (genvar j = 0; j < WIN; j++) begin : g_col
            localparam logic [AW-1:0] OI = AW'(i);
            localparam logic [AW-1:0] OJ = AW'(j);
            logic [AW-1:0] taddr;
            assign taddr = (AW'(nx) + OI) * AW'(IMG_W) + AW'(ny) + OJ;
            assign imgin_d[(i*WIN+j)*PIX_W +: PIX_W] = mem[taddr];
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and datapath control strobes.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        load_win  = 1'b0;
        end_scan  = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    start_acc = 1'b1;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (!VALID || accept) begin
                    if (VALID && last_win) begin
                        end_scan = 1'b1;
                        state_d  = WAIT_DONE;
                    end else begin
                        load_win = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (CNN_DONE) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Image buffer: cleared on reset, written only while idle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < NPIX; k++) mem[k] <= '0;
        end else if (wr_en) begin
            mem[WADDR] <= WDATA;
        end
    end

    // Window output registers, busy flag and result capture.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            X            <= '0;
            Y            <= '0;
            IMGIN        <= '0;
            VALID        <= 1'b0;
            BUSY         <= 1'b0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
        end else begin
            RESULT_VALID <= capture;
            if (start_acc) BUSY <= 1'b1;
            if (load_win) begin
                X     <= nx;
                Y     <= ny;
                IMGIN <= imgin_d;
                VALID <= 1'b1;
            end
            if (end_scan) VALID <= 1'b0;
            if (capture) begin
                RESULT <= CNN_OUT;
                BUSY   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cnn_window_feeder.sv
// Directed bench for cnn_window_feeder: full raster scans against an image
// model, ignored-event injection, result handshake, back-to-back scans,
// async reset mid-scan, and READY back-pressure when the macro is defined.
module tb_cnn_window_feeder;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         WE = 1'b0;
    logic [9:0]   WADDR = '0;
    logic [7:0]   WDATA = '0;
    logic         START = 1'b0;
    logic         BUSY;
    logic [4:0]   X, Y;
    logic [199:0] IMGIN;
    logic         VALID;
    logic         CNN_DONE = 1'b0;
    logic [3:0]   CNN_OUT = '0;
    logic [3:0]   RESULT;
    logic         RESULT_VALID;
`ifdef CNN_WINDOW_FEEDER_READY_EN
    logic         READY = 1'b1;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] img_m [784];

    cnn_window_feeder dut (
        .CLK(CLK), .nRST(nRST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .START(START), .BUSY(BUSY), .X(X), .Y(Y), .IMGIN(IMGIN), .VALID(VALID),
`ifdef CNN_WINDOW_FEEDER_READY_EN
        .READY(READY),
`endif
        .CNN_DONE(CNN_DONE), .CNN_OUT(CNN_OUT), .RESULT(RESULT),
        .RESULT_VALID(RESULT_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int b);
        logic [199:0] v;
        v = IMGIN;
        return v[b*8 +: 8];
    endfunction

    function automatic logic [7:0] exp_pix(input int x, input int y, input int i, input int j);
        return img_m[(x + i) * 28 + y + j];
    endfunction

    // Load image; kind 0: k mod 256, kind 1: (3k+1) mod 256.
    task automatic load_img(input int kind);
        for (int k = 0; k < 784; k++) begin
            img_m[k] = (kind == 0) ? 8'(k) : 8'(3 * k + 1);
            WE = 1'b1; WADDR = 10'(k); WDATA = img_m[k];
            @(negedge CLK);
        end
        WE = 1'b0;
    endtask

    // Starts a scan from a negedge and follows it to the end; returns at a
    // negedge with VALID low. inject drives ignorable events mid-scan.
    task automatic run_scan(input bit inject, input bit img_a);
        int n, cyc, rv_seen, stall;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("busy_after_start", 32'(BUSY), 1);
        chk("valid_not_yet", 32'(VALID), 0);
        @(negedge CLK);
        n = 0; cyc = 0; rv_seen = 0; stall = 0;
        while (VALID && cyc < 2000) begin
            chk("win_x",  32'(X), 32'(n / 24));
            chk("win_y",  32'(Y), 32'(n % 24));
            chk("win_b0", 32'(byte_of(0)), 32'(exp_pix(n / 24, n % 24, 0, 0)));
            chk("win_b12", 32'(byte_of(12)), 32'(exp_pix(n / 24, n % 24, 2, 2)));
            chk("win_b24", 32'(byte_of(24)), 32'(exp_pix(n / 24, n % 24, 4, 4)));
            if (img_a && n == 0) begin
                chk("first_b0", 32'(byte_of(0)), 0);
                chk("first_b24", 32'(byte_of(24)), 116);
            end
            if (img_a && n == 23) chk("x0y23_b0", 32'(byte_of(0)), 23);
            if (img_a && n == 575) begin
                chk("last_b0", 32'(byte_of(0)), 155);
                chk("last_b24", 32'(byte_of(24)), 15);
            end
            if (RESULT_VALID) rv_seen++;
            WE = 1'b0; START = 1'b0; CNN_DONE = 1'b0;
            if (inject && n == 100) begin
                WE = 1'b1; WADDR = 10'd0; WDATA = 8'hFF;
                START = 1'b1; CNN_DONE = 1'b1; CNN_OUT = 4'd5;
            end
`ifdef CNN_WINDOW_FEEDER_READY_EN
            if (n == 5 * 24 + 12 && stall < 10) begin
                READY = 1'b0;
                stall++;
            end else begin
                READY = 1'b1;
                n++;
            end
`else
            n++;
`endif
            cyc++;
            @(negedge CLK);
        end
        WE = 1'b0; START = 1'b0; CNN_DONE = 1'b0;
`ifdef CNN_WINDOW_FEEDER_READY_EN
        READY = 1'b1;
        chk("stall_cycles", 32'(stall), 10);
`endif
        chk("valid_count", 32'(n), 576);
        chk("no_early_result", 32'(rv_seen), 0);
        chk("hold_x", 32'(X), 23);
        chk("hold_y", 32'(Y), 23);
        chk("busy_wait", 32'(BUSY), 1);
    endtask

    // Returns the class in WAIT_DONE, with a START in the same cycle.
    task automatic do_result(input logic [3:0] cls);
        repeat (3) @(negedge CLK);
        chk("wait_valid_low", 32'(VALID), 0);
        chk("wait_no_rv", 32'(RESULT_VALID), 0);
        CNN_DONE = 1'b1; CNN_OUT = cls; START = 1'b1;
        @(posedge CLK); #1;
        chk("result", 32'(RESULT), 32'(cls));
        chk("result_valid", 32'(RESULT_VALID), 1);
        chk("busy_drop", 32'(BUSY), 0);
        @(negedge CLK);
        CNN_DONE = 1'b0; START = 1'b0;
        @(negedge CLK);
        chk("rv_one_cycle", 32'(RESULT_VALID), 0);
        chk("start_w_done_ign", 32'(BUSY), 0);
        chk("idle_valid", 32'(VALID), 0);
        chk("result_hold", 32'(RESULT), 32'(cls));
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_valid", 32'(VALID), 0);
        chk("rst_result", 32'(RESULT), 0);
        chk("rst_imgin", 32'(IMGIN[31:0]), 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // scan 1: image A with injected ignorable events, class 7
        load_img(0);
        run_scan(1'b1, 1'b1);
        chk("hold_b0", 32'(byte_of(0)), 155);
        do_result(4'd7);

        // scan 2: same image, write at addr 0 must not have landed; class 3
        run_scan(1'b0, 1'b1);
        do_result(4'd3);

        // scan 3: new image back-to-back, class 9
        load_img(1);
        run_scan(1'b0, 1'b0);
        do_result(4'd9);

        // async reset mid-scan
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (40) @(negedge CLK);
        chk("pre_rst_valid", 32'(VALID), 1);
        #2 nRST = 1'b0;
        #1;
        chk("arst_valid", 32'(VALID), 0);
        chk("arst_busy", 32'(BUSY), 0);
        chk("arst_x", 32'(X), 0);
        chk("arst_y", 32'(Y), 0);
        chk("arst_result", 32'(RESULT), 0);
        chk("arst_imgin", 32'(IMGIN[63:0] != 0), 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        chk("post_rst_valid", 32'(VALID), 0);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        chk("rescan_valid", 32'(VALID), 1);
        chk("rescan_x", 32'(X), 0);
        chk("rescan_y", 32'(Y), 0);
        chk("cleared_b0", 32'(byte_of(0)), 0);
        chk("cleared_b24", 32'(byte_of(24)), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnn_window_feeder.md
Name: cnn_window_feeder

Overview:
- Producer side of the simpleCNN window interface: holds one 28x28 8-bit image and streams every 5x5 window in raster order with its X/Y coordinates.
- Waits for the CNN's DONE/OUT, then reports the class result upstream.
- Replaces bench-driven window generation so that image loading and classification run in hardware.

Parameters:
- IMG_W, 28, image side length in pixels (square image).
- WIN, 5, window side length.
- PIX_W, 8, bits per pixel.
- Derived, not overridable: POS = IMG_W-WIN+1 (24), positions per axis. Coordinate width is 5 bits.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- WE  in  1  image buffer write enable.
- WADDR  in  10  pixel address, row*IMG_W+col, 0..783.
- WDATA  in  8  pixel value.
- START  in  1  begin scan of the stored image.
- BUSY  out  1  high from START acceptance until result is returned.
- X  out  5  window row origin.
- Y  out  5  window column origin.
- IMGIN  out  200  window pixels; byte (i*5+j) = img[(X+i)*28+(Y+j)], i,j in 0..4.
- VALID  out  1  X/Y/IMGIN are valid this cycle.
- CNN_DONE  in  1  classification complete, from the CNN.
- CNN_OUT  in  4  class index from the CNN.
- RESULT  out  4  captured class.
- RESULT_VALID  out  1  one-cycle pulse when RESULT is updated.

Behaviour:
- Reset (async, nRST=0) state:
  - FSM = IDLE.
  - X, Y, IMGIN, VALID, BUSY, RESULT, RESULT_VALID = 0.
  - Image buffer cleared to 0.
- Buffer writes:
  - Accepted only in IDLE.
  - WE in any other state is ignored.
  - WADDR > 783 is ignored.
- FSM states: IDLE -> SCAN -> WAIT_DONE -> IDLE.
- IDLE:
  - START=1 at a rising edge moves to SCAN and sets BUSY.
  - On the following edge the first window is registered: X=0, Y=0, VALID=1. Latency from START is 1 cycle.
- SCAN:
  - One window per cycle; all outputs are registered.
  - Y increments each cycle. When Y=23, Y wraps to 0 and X increments.
  - After the window X=23, Y=23 is presented, the next edge drops VALID and moves to WAIT_DONE.
  - Exactly 576 consecutive VALID cycles.
- START while BUSY is ignored.
- CNN_DONE before WAIT_DONE is ignored; it is not latched.
- WAIT_DONE:
  - CNN_DONE=1 captures RESULT <= CNN_OUT.
  - RESULT_VALID pulses for 1 cycle, BUSY clears, FSM returns to IDLE on the same edge.
  - START in the same cycle as that DONE is ignored.
- Between scans: X, Y, IMGIN hold their last values while VALID=0. RESULT holds until the next capture.
- Reset mid-SCAN or mid-WAIT_DONE: immediate return to IDLE with all outputs zeroed. A later START rescans from X=0, Y=0.
- Addressing: all window indices are computed in unsigned arithmetic at least 10 bits wide; no out-of-range access is possible since X, Y <= 23.

Optional Feature:
- Macro CNN_WINDOW_FEEDER_READY_EN.
- When defined:
  - Adds input READY (1 bit).
  - In SCAN, a window advances only on a cycle where VALID=1 and READY=1.
  - While READY=0, X/Y/IMGIN/VALID hold.
  - The final window leaves SCAN only after it is accepted.
- When undefined:
  - No READY port.
  - The stream advances unconditionally every cycle, as described above.

Test Plan:
- Reset: drive nRST=0 mid-operation -> all outputs 0 asynchronously; after release, START produces X=0, Y=0 on the next edge.
- Full scan: load pixel k = k mod 256, then pulse START.
  - First window: byte0=0, byte24=116.
  - Window X=0, Y=23: byte0=23.
  - Window X=1, Y=0 follows it.
  - Last window X=23, Y=23: byte0=155, byte24=15.
  - VALID is high for exactly 576 consecutive cycles.
- Result handshake: after the scan, assert CNN_DONE=1 with CNN_OUT=7 -> RESULT=7 and a single-cycle RESULT_VALID; BUSY drops the same edge.
- Ignored events: WE during SCAN with WADDR=0, WDATA=FF -> the next scan's first byte0 is still 0. START during SCAN does not restart the scan. Early CNN_DONE during SCAN gives no RESULT_VALID.
- Back-to-back: two images loaded and scanned in sequence with CNN_OUT 3 then 9 -> RESULT sequence 3, 9 with no window loss.
- READY (macro defined): hold READY=0 for 10 cycles at X=5, Y=12 -> outputs frozen; after release the scan resumes at X=5, Y=13 and the total accepted window count is 576.
